cmem_fill: RTL and testbench

- Line-fill engine directly downstream of the shared L2 cache's external read port.
- When the cache misses, it asserts a block-address read request. This block splits that request into BEATS bus-wide reads on the memory bus, collects the returning beats in order, and returns one full cache line with a single-cycle data-valid pulse.
- Supports pipelined address issue: several beats may be outstanding at once.

---
 rtl/cmem_fill.sv | 134 +++++++++++++
 tb/tb_cmem_fill.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_fill.sv
// cmem_fill: splits an L2 line-fill request into BUS_W-wide beat reads and reassembles the line.
// Define CMEM_FILL_TIMEOUT_EN to add the idle watchdog, fill_err output and late-beat discard.
module cmem_fill #(
  parameter int LINE_W = 512,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 64 - $clog2(LINE_W/8)
`ifdef CMEM_FILL_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] b_addr_c,
  input  logic              b_rd_c,
  output logic [LINE_W-1:0] b_rdata_c,
  output logic              b_dv_c,
  output logic [63:0]       m_addr,
  output logic              m_rd,
  input  logic              m_gnt,
  input  logic [BUS_W-1:0]  m_rdata,
  input  logic              m_rvalid,
  output logic              busy
`ifdef CMEM_FILL_TIMEOUT_EN
  , output logic            fill_err
`endif
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int IW    = $clog2(BEATS);
  localparam int CW    = IW + 1;
  localparam int OW    = $clog2(BUS_W / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_blk;
  logic [CW-1:0]     r_iss, r_rx;
  logic [LINE_W-1:0] r_line;
  logic              w_active, w_acc, w_cap, w_last_gnt, w_last_rx, w_timeout;

  assign w_active   = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_acc      = (r_state == ISSUE) && m_gnt;
  assign w_last_gnt = w_acc && (r_iss == LAST);
  assign w_last_rx  = w_cap && (r_rx == LAST);

  assign m_rd      = (r_state == ISSUE);
  assign m_addr    = {r_blk, r_iss[IW-1:0], {OW{1'b0}}};
  assign busy      = (r_state != IDLE);
  assign b_dv_c    = (r_state == DONE);
  assign b_rdata_c = r_line;

`ifdef CMEM_FILL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_wdog;
  logic [CW-1:0] r_disc;
  logic          r_err;

  // Beats left over from a timed-out fill are swallowed before anything new is captured.
  assign w_cap     = w_active && m_rvalid && (r_disc == '0);
  assign w_timeout = w_active && !w_acc && !m_rvalid && (r_wdog == WW'(TIMEOUT - 1));
  assign fill_err  = (r_state == DONE) && r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
      r_disc <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == IDLE && b_rd_c)
        r_err <= 1'b0;
      if (w_active && !w_acc && !m_rvalid)
        r_wdog <= r_wdog + WW'(1);
      else
        r_wdog <= '0;
      if (w_timeout) begin
        r_disc <= r_iss - r_rx;
        r_err  <= 1'b1;
      end else if (m_rvalid && r_disc != '0) begin
        r_disc <= r_disc - CW'(1);
      end
    end
  end
`else
  assign w_cap     = w_active && m_rvalid;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (b_rd_c) w_next = ISSUE;
      ISSUE: begin
        if (w_timeout)       w_next = DONE;
        else if (w_last_gnt) w_next = w_last_rx ? DONE : DRAIN;
      end
      DRAIN:   if (w_last_rx || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The line buffer is not cleared between fills so the last line stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_iss   <= '0;
      r_rx    <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && b_rd_c) begin
        r_blk <= b_addr_c;
        r_iss <= '0;
        r_rx  <= '0;
      end
      if (w_acc)
        r_iss <= r_iss + CW'(1);
      if (w_cap) begin
        r_line[r_rx[IW-1:0]*BUS_W +: BUS_W] <= m_rdata;
        r_rx <= r_rx + CW'(1);
      end
`ifdef CMEM_FILL_TIMEOUT_EN
      if (w_timeout) begin
        for (int k = 0; k < BEATS; k++)
          if (CW'(k) >= r_rx) r_line[k*BUS_W +: BUS_W] <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmem_fill.sv
// tb_cmem_fill: self-checking bench for cmem_fill with a queue-based memory responder and line model.
// Define CMEM_FILL_TIMEOUT_EN to also exercise the watchdog path (TIMEOUT=16).
module tb_cmem_fill;

  localparam int LINE_W = 512;
  localparam int BUS_W  = 64;
  localparam int BEATS  = 8;
  localparam int ADDR_W = 58;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] b_addr_c;
  logic              b_rd_c;
  logic [LINE_W-1:0] b_rdata_c;
  logic              b_dv_c;
  logic [63:0]       m_addr;
  logic              m_rd;
  logic              m_gnt;
  logic [BUS_W-1:0]  m_rdata;
  logic              m_rvalid;
  logic              busy;
`ifdef CMEM_FILL_TIMEOUT_EN
  logic              fill_err;
`endif

  cmem_fill #(
    .LINE_W(LINE_W)
`ifdef CMEM_FILL_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .b_addr_c(b_addr_c), .b_rd_c(b_rd_c),
    .b_rdata_c(b_rdata_c), .b_dv_c(b_dv_c), .m_addr(m_addr), .m_rd(m_rd),
    .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .busy(busy)
`ifdef CMEM_FILL_TIMEOUT_EN
    , .fill_err(fill_err)
`endif
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;

  // responder controls
  int gntPct = 100, rvPct = 100, stallBeat = -1, stallLeft = 0, rvLimit = 1000;
  bit holdResp = 0, dataIdx = 0;
  bit rvPat[$];

  // memory model state: in-flight data, and what was granted in the current fill
  logic [63:0] pend[$];
  logic [63:0] expData[$];
  logic [63:0] expAddr[$];
  int grantCnt = 0, rxCnt = 0;
  logic sRd;
  logic [63:0] sAddr;

  always @(negedge clk) begin
    sRd   = m_rd;
    sAddr = m_addr;
  end

  // In-order memory: grants push data, rvalid pops the oldest outstanding beat.
  always @(posedge clk) begin : responder
    logic [63:0] d;
    bit go;
    if (rst) begin
      pend.delete();
    end else begin
      if (m_rvalid) begin
        void'(pend.pop_front());
        rxCnt++;
      end
      if (sRd && m_gnt) begin
        d = dataIdx ? 64'(sAddr[5:3]) : {$urandom, $urandom};
        pend.push_back(d);
        expData.push_back(d);
        expAddr.push_back(sAddr);
        grantCnt++;
      end
    end
    #1;
    if (rst) m_gnt = 1'b0;
    else if (m_rd && grantCnt == stallBeat && stallLeft > 0) begin
      m_gnt = 1'b0;
      stallLeft--;
    end else m_gnt = ($urandom_range(99) < gntPct);
    go = 1'b0;
    if (!rst && pend.size() > 0 && rxCnt < rvLimit && !(holdResp && grantCnt < BEATS)) begin
      if (rvPat.size() > 0) go = rvPat.pop_front();
      else go = ($urandom_range(99) < rvPct);
    end
    m_rvalid = go;
    m_rdata  = go ? pend[0] : {$urandom, $urandom};
  end

  function automatic logic [LINE_W-1:0] model_line(input int nValid);
    logic [LINE_W-1:0] l = '0;
    for (int k = 0; k < BEATS; k++)
      if (k < nValid && k < expData.size()) l[k*BUS_W +: BUS_W] = expData[k];
    return l;
  endfunction

  task automatic start_fill(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    expData.delete();
    expAddr.delete();
    grantCnt = 0;
    rxCnt    = 0;
    b_addr_c = a;
    b_rd_c   = 1'b1;
  endtask

  // Waits for b_dv_c; the cache drops its request on the pulse.
  task automatic wait_dv(input int limit, input bit scramble, output int cyc,
                         output logic [LINE_W-1:0] line, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    line = '0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (b_dv_c) begin
        seen   = 1'b1;
        line   = b_rdata_c;
        b_rd_c = 1'b0;
      end else if (scramble) begin
        b_addr_c = {$urandom, $urandom};
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nCmp++; if (b_dv_c !== 1'b0) begin nFail++; $display("[TB] FAIL reset_dv: got %b expected 0", b_dv_c); end
    nCmp++; if (m_rd !== 1'b0) begin nFail++; $display("[TB] FAIL reset_mrd: got %b expected 0", m_rd); end
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nCmp++; if (b_rdata_c !== '0) begin nFail++; $display("[TB] FAIL reset_rdata: got %0h expected 0", b_rdata_c); end
`ifdef CMEM_FILL_TIMEOUT_EN
    nCmp++; if (fill_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err: got %b expected 0", fill_err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    int cyc;
    bit seen;
    logic [LINE_W-1:0] line, held;
    dataIdx = 1;
    start_fill(58'h40);
    wait_dv(40, 0, cyc, line, seen);
    nCmp++; if (!seen || cyc != 10) begin nFail++; $display("[TB] FAIL zw_latency: got seen=%0d cycle %0d expected cycle 10", seen, cyc); end
    for (int k = 0; k < BEATS; k++) begin
      nCmp++;
      if (line[k*BUS_W +: BUS_W] !== 64'(k)) begin nFail++; $display("[TB] FAIL zw_beat%0d: got %0h expected %0h", k, line[k*BUS_W +: BUS_W], k); end
    end
    nCmp++; if (expAddr.size() != BEATS) begin nFail++; $display("[TB] FAIL zw_ngrant: got %0d expected %0d", expAddr.size(), BEATS); end
    for (int k = 0; k < BEATS && k < expAddr.size(); k++) begin
      nCmp++;
      if (expAddr[k] !== 64'h1000 + 64'(8*k)) begin nFail++; $display("[TB] FAIL zw_addr%0d: got %0h expected %0h", k, expAddr[k], 64'h1000 + 64'(8*k)); end
    end
    @(negedge clk);
    held = b_rdata_c;
    nCmp++; if (b_dv_c !== 1'b0) begin nFail++; $display("[TB] FAIL zw_pulse: got %b expected 0", b_dv_c); end
    nCmp++; if (held !== line) begin nFail++; $display("[TB] FAIL zw_hold: got %0h expected %0h", held, line); end
    dataIdx = 0;
  endtask

  task automatic test_gnt_stall();
    int cyc, stalls;
    bit seen;
    logic [LINE_W-1:0] line;
    stallBeat = 2;
    stallLeft = 3;
    stalls = 0;
    start_fill(58'h40);
    seen = 1'b0;
    cyc = 0;
    line = '0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_rd && !m_gnt) begin
        stalls++;
        nCmp++;
        if (m_addr !== 64'h1010) begin nFail++; $display("[TB] FAIL stall_addr: got %0h expected 1010", m_addr); end
      end
      if (b_dv_c) begin seen = 1'b1; line = b_rdata_c; b_rd_c = 1'b0; end
    end
    nCmp++; if (stalls != 3) begin nFail++; $display("[TB] FAIL stall_count: got %0d expected 3", stalls); end
    nCmp++; if (!seen || cyc != 13) begin nFail++; $display("[TB] FAIL stall_latency: got seen=%0d cycle %0d expected cycle 13", seen, cyc); end
    nCmp++; if (line !== model_line(BEATS)) begin nFail++; $display("[TB] FAIL stall_line: got %0h expected %0h", line, model_line(BEATS)); end
    stallBeat = -1;
  endtask

  task automatic test_burst_resp();
    int dvCount;
    bit afterDv;
    logic [LINE_W-1:0] line;
    holdResp = 1;
    rvPat = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 1};
    dvCount = 0;
    afterDv = 1'b0;
    line = '0;
    start_fill({$urandom, $urandom});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (afterDv) begin
        afterDv = 1'b0;
        nCmp++;
        if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL burst_busy: got %b expected 0", busy); end
      end
      if (b_dv_c) begin dvCount++; line = b_rdata_c; b_rd_c = 1'b0; afterDv = 1'b1; end
    end
    nCmp++; if (dvCount != 1) begin nFail++; $display("[TB] FAIL burst_pulses: got %0d expected 1", dvCount); end
    nCmp++; if (line !== model_line(BEATS)) begin nFail++; $display("[TB] FAIL burst_line: got %0h expected %0h", line, model_line(BEATS)); end
    holdResp = 0;
  endtask

  task automatic test_reset_midfill();
    int cyc, bound, dvDuringAbort;
    bit seen;
    logic [LINE_W-1:0] line;
    dvDuringAbort = 0;
    start_fill(58'h40);
    bound = 0;
    while (rxCnt < 4 && bound < 30) begin
      @(negedge clk);
      bound++;
    end
    nCmp++; if (rxCnt != 4) begin nFail++; $display("[TB] FAIL abort_reach: got rx %0d expected 4", rxCnt); end
    rst = 1'b1;
    b_rd_c = 1'b0;
    repeat (2) begin @(negedge clk); if (b_dv_c) dvDuringAbort++; end
    nCmp++; if (b_rdata_c !== '0) begin nFail++; $display("[TB] FAIL abort_rdata: got %0h expected 0", b_rdata_c); end
    rst = 1'b0;
    repeat (15) begin @(negedge clk); if (b_dv_c) dvDuringAbort++; end
    nCmp++; if (dvDuringAbort != 0) begin nFail++; $display("[TB] FAIL abort_dv: got %0d pulses expected 0", dvDuringAbort); end
    start_fill(58'h7);
    wait_dv(40, 0, cyc, line, seen);
    nCmp++; if (!seen || cyc != 10) begin nFail++; $display("[TB] FAIL abort_latency: got seen=%0d cycle %0d expected cycle 10", seen, cyc); end
    nCmp++; if (line !== model_line(BEATS)) begin nFail++; $display("[TB] FAIL abort_line: got %0h expected %0h", line, model_line(BEATS)); end
    for (int k = 0; k < BEATS; k++) begin
      nCmp++;
      if (k >= expAddr.size() || expAddr[k] !== 64'h1C0 + 64'(8*k)) begin nFail++; $display("[TB] FAIL abort_addr%0d: got %0h expected %0h", k, (k < expAddr.size()) ? expAddr[k] : 64'hx, 64'h1C0 + 64'(8*k)); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    logic [LINE_W-1:0] line, exp1;
    logic [ADDR_W-1:0] blkB;
    start_fill({$urandom, $urandom});
    wait_dv(40, 0, cyc, line, seen);
    exp1 = model_line(BEATS);
    nCmp++; if (!seen || line !== exp1) begin nFail++; $display("[TB] FAIL b2b_first: got %0h expected %0h", line, exp1); end
    blkB = {$urandom, $urandom};
    start_fill(blkB);
    @(negedge clk);
    nCmp++; if (m_rd !== 1'b1 || m_addr !== {blkB, 6'b0}) begin nFail++; $display("[TB] FAIL b2b_start: got rd=%b addr %0h expected rd=1 addr %0h", m_rd, m_addr, {blkB, 6'b0}); end
    wait_dv(40, 0, cyc, line, seen);
    nCmp++; if (!seen || cyc != 9) begin nFail++; $display("[TB] FAIL b2b_latency: got seen=%0d cycle %0d expected cycle 9", seen, cyc); end
    nCmp++; if (line !== model_line(BEATS)) begin nFail++; $display("[TB] FAIL b2b_second: got %0h expected %0h", line, model_line(BEATS)); end
  endtask

  task automatic test_random();
    int cyc;
    bit seen;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] blk;
    for (int f = 0; f < 6; f++) begin
      gntPct = $urandom_range(30, 100);
      rvPct  = $urandom_range(30, 100);
      blk = {$urandom, $urandom};
      start_fill(blk);
      wait_dv(400, 1, cyc, line, seen);
      nCmp++; if (!seen || line !== model_line(BEATS)) begin nFail++; $display("[TB] FAIL rand%0d_line: got seen=%0d %0h expected %0h", f, seen, line, model_line(BEATS)); end
      for (int k = 0; k < BEATS; k++) begin
        nCmp++;
        if (k >= expAddr.size() || expAddr[k] !== {blk, 6'b0} + 64'(8*k)) begin nFail++; $display("[TB] FAIL rand%0d_addr%0d: got %0h expected %0h", f, k, (k < expAddr.size()) ? expAddr[k] : 64'hx, {blk, 6'b0} + 64'(8*k)); end
      end
    end
    gntPct = 100;
    rvPct  = 100;
  endtask

`ifdef CMEM_FILL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bit seen;
    logic err;
    logic [LINE_W-1:0] line;
    rvLimit = 5;
    start_fill({$urandom, $urandom});
    wait_dv(80, 0, cyc, line, seen);
    err = fill_err;
    nCmp++; if (!seen || err !== 1'b1) begin nFail++; $display("[TB] FAIL to_err: got seen=%0d err=%b expected 1", seen, err); end
    nCmp++; if (line !== model_line(5)) begin nFail++; $display("[TB] FAIL to_line: got %0h expected %0h", line, model_line(5)); end
    rvLimit = 1000;
    start_fill({$urandom, $urandom});
    wait_dv(80, 0, cyc, line, seen);
    err = fill_err;
    nCmp++; if (!seen || err !== 1'b0) begin nFail++; $display("[TB] FAIL to_next_err: got seen=%0d err=%b expected 0", seen, err); end
    nCmp++; if (line !== model_line(BEATS)) begin nFail++; $display("[TB] FAIL to_next_line: got %0h expected %0h", line, model_line(BEATS)); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    b_rd_c = 1'b0;
    b_addr_c = '0;
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    test_reset();
    test_zero_wait();
    test_gnt_stall();
    test_burst_resp();
    test_reset_midfill();
    test_back_to_back();
    test_random();
`ifdef CMEM_FILL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no completion expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
